// File: rtl/icb_mst_pkg.sv
// Shared constants, state encodings and command payload for the ICB master port.
package icb_mst_pkg;

  localparam int unsigned ICB_AW          = 32;
  localparam int unsigned ICB_DW          = 32;
  localparam int unsigned DEF_TIMEOUT_CYC = 256;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  typedef struct packed {
    logic              read;
    logic [ICB_AW-1:0] addr;
    logic [ICB_DW-1:0] wdata;
  } icb_cmd_t;

endpackage

// File: rtl/icb_master_port_if.sv
// ICB command/response channel bundle with initiator and target views.
interface icb_master_port_if;
  import icb_mst_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ICB_AW-1:0] cmd_addr;
  logic              cmd_read;
  logic [ICB_DW-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ICB_DW-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_read, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/icb_mst_timer.sv
// Saturating response timer; expired_c flags that the allowed window has run out.
module icb_mst_timer #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = (count >= LIMIT);

endmodule

// File: rtl/icb_master_port.sv
// Single-outstanding ICB initiator: local request/done handshake to ICB cmd/rsp,
// with response timeout and a saturating count of responses seen while idle.
module icb_master_port
  import icb_mst_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned STRAY_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_read,
  input  logic [ICB_AW-1:0]  req_addr,
  input  logic [ICB_DW-1:0]  req_wdata,
  output logic               done_valid,
  output logic [ICB_DW-1:0]  done_rdata,
  output logic               done_err,
  icb_master_port_if.master  icb,
  output logic [STRAY_W-1:0] stray_cnt,
  output logic               busy
);

  logic [1:0]        state, state_nxt;
  icb_cmd_t          cmd_q;
  logic              cmd_valid_q, cmd_valid_nxt;
  logic              req_ready_nxt;
  logic              done_valid_nxt, done_err_nxt;
  logic [ICB_DW-1:0] done_rdata_nxt;
  logic              accept_c;
  logic              expired_c;

  assign accept_c = req_valid & req_ready;
  assign busy     = (state != ST_IDLE);

  icb_mst_timer #(
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (accept_c),
    .en        (busy),
    .expired_c (expired_c)
  );

  // Next state and completion; a response in the timeout cycle takes priority.
  always_comb begin
    state_nxt      = state;
    cmd_valid_nxt  = cmd_valid_q;
    done_valid_nxt = 1'b0;
    done_err_nxt   = 1'b0;
    done_rdata_nxt = '0;
    case (state)
      ST_IDLE: begin
        if (accept_c) begin
          state_nxt     = ST_CMD;
          cmd_valid_nxt = 1'b1;
        end
      end
      ST_CMD: begin
        if (icb.cmd_ready && icb.rsp_valid) begin
          state_nxt      = ST_IDLE;
          cmd_valid_nxt  = 1'b0;
          done_valid_nxt = 1'b1;
          done_err_nxt   = icb.rsp_err;
          done_rdata_nxt = (cmd_q.read && !icb.rsp_err) ? icb.rsp_rdata : '0;
        end else if (expired_c) begin
          state_nxt      = ST_IDLE;
          cmd_valid_nxt  = 1'b0;
          done_valid_nxt = 1'b1;
          done_err_nxt   = 1'b1;
        end else if (icb.cmd_ready) begin
          state_nxt     = ST_RSP;
          cmd_valid_nxt = 1'b0;
        end
      end
      ST_RSP: begin
        if (icb.rsp_valid) begin
          state_nxt      = ST_IDLE;
          done_valid_nxt = 1'b1;
          done_err_nxt   = icb.rsp_err;
          done_rdata_nxt = (cmd_q.read && !icb.rsp_err) ? icb.rsp_rdata : '0;
        end else if (expired_c) begin
          state_nxt      = ST_IDLE;
          done_valid_nxt = 1'b1;
          done_err_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt     = ST_IDLE;
        cmd_valid_nxt = 1'b0;
      end
    endcase
    req_ready_nxt = (state_nxt == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      req_ready   <= 1'b0;
      done_valid  <= 1'b0;
      done_rdata  <= '0;
      done_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_valid_q <= cmd_valid_nxt;
      req_ready   <= req_ready_nxt;
      done_valid  <= done_valid_nxt;
      done_rdata  <= done_rdata_nxt;
      done_err    <= done_err_nxt;
      if (accept_c) begin
        cmd_q <= '{read: req_read, addr: req_addr, wdata: req_wdata};
      end
    end
  end

  // Responses arriving with nothing outstanding are swallowed and counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stray_cnt <= '0;
    end else if ((state == ST_IDLE) && icb.rsp_valid && (stray_cnt != '1)) begin
      stray_cnt <= stray_cnt + STRAY_W'(1);
    end
  end

  assign icb.cmd_valid = cmd_valid_q;
  assign icb.cmd_addr  = cmd_q.addr;
  assign icb.cmd_read  = cmd_q.read;
  assign icb.cmd_wdata = cmd_q.wdata;
  assign icb.rsp_ready = 1'b1;

endmodule

// File: tb/tb_icb_master_port.sv
// Randomised scoreboard bench for icb_master_port with a transaction-level timing model.
module tb_icb_master_port;
  import icb_mst_pkg::*;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_read = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        done_valid;
  logic [31:0] done_rdata;
  logic        done_err;
  logic [7:0]  stray_cnt;
  logic        busy;

  icb_master_port_if icb ();

  icb_master_port #(.TIMEOUT_CYC(T), .CNT_W(16), .STRAY_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_read   (req_read),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .done_valid (done_valid),
    .done_rdata (done_rdata),
    .done_err   (done_err),
    .icb        (icb),
    .stray_cnt  (stray_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   stray_model = 0;
  int   last_accept = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        check("done_cycle", 96'(cyc), 96'(e.at));
        check("done_rdata", 96'(done_rdata), 96'(e.rdata));
        check("done_err", 96'(done_err), 96'(e.err));
      end
    end
  end

  // One transaction; target accepts cmd after d cycles and responds r cycles after that.
  task automatic do_txn(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input int d, input int r, input logic resp,
                        input logic [31:0] rdata, input logic err, input logic keep);
    int   a;
    int   jend;
    int   n;
    logic hit;
    req_read  = rd;
    req_addr  = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) begin
      tests++;
      fails++;
      $display("FAIL req_ready_wait: got 0 expected 1 within 20 cycles");
      req_valid = 1'b0;
      return;
    end
    a = cyc;
    last_accept = a;
    hit = resp && (d + r <= T - 1);
    if (hit) q.push_back('{a + 2 + d + r, (rd && !err) ? rdata : 32'h0, err});
    else     q.push_back('{a + 1 + T, 32'h0, 1'b1});
    jend = hit ? d + r : T - 1;
    for (int j = 0; j <= jend; j++) begin
      @(posedge clk); #1;
      if (j == 0 && !keep) req_valid = 1'b0;
      if (j <= d) begin
        check("cmd_valid", 96'(icb.cmd_valid), 96'(1));
        check("cmd_fields", {31'h0, icb.cmd_read, icb.cmd_addr, icb.cmd_wdata}, {31'h0, rd, addr, wdata});
        check("req_ready_busy", 96'({req_ready, busy}), 96'(2'b01));
      end
      icb.cmd_ready = (j == d);
      icb.rsp_valid = resp && (j == d + r);
      icb.rsp_rdata = icb.rsp_valid ? rdata : $urandom;
      icb.rsp_err   = icb.rsp_valid ? err : 1'($urandom);
    end
    @(posedge clk); #1;
    icb.cmd_ready = 1'b0;
    icb.rsp_valid = 1'b0;
  endtask

  task automatic stray_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      icb.rsp_valid = 1'b1;
      icb.rsp_rdata = $urandom;
      @(posedge clk); #1;
    end
    icb.rsp_valid = 1'b0;
    stray_model = (stray_model + n > 255) ? 255 : stray_model + n;
  endtask

  initial begin
    int prev;
    int n;
    icb.cmd_ready = 1'b0;
    icb.rsp_valid = 1'b0;
    icb.rsp_rdata = '0;
    icb.rsp_err   = 1'b0;
    #2;
    check("rst_outputs", 96'({icb.cmd_valid, done_valid, done_err, busy, req_ready}), 96'(0));
    check("rst_data", {done_rdata, icb.cmd_addr, 24'h0, stray_cnt}, 96'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("req_ready_after_rst", 96'(req_ready), 96'(1));

    do_txn(1'b0, 32'h04, 32'hDEADBEEF, 0, 0, 1'b1, 32'h0, 1'b0, 1'b0);
    do_txn(1'b1, 32'h08, 32'h0, 0, 1, 1'b1, 32'h12345678, 1'b0, 1'b0);
    do_txn(1'b0, 32'h10, 32'hCAFEF00D, 3, 1, 1'b1, 32'h0, 1'b0, 1'b0);
    do_txn(1'b1, 32'h20, 32'h0, 0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("idle_after_timeout", 96'(busy), 96'(0));
    stray_pulses(1);
    #1 check("stray_after_late_rsp", 96'(stray_cnt), 96'(1));
    do_txn(1'b1, 32'h24, 32'h0, 0, 1, 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    do_txn(1'b1, 32'h28, 32'h0, 3, 4, 1'b1, 32'h0BADF00D, 1'b0, 1'b0);
    do_txn(1'b1, 32'h2C, 32'h0, 4, 4, 1'b1, 32'h11111111, 1'b0, 1'b0);
    do_txn(1'b0, 32'h30, 32'h77, 99, 0, 1'b1, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      do_txn(1'($urandom), $urandom, $urandom, int'($urandom_range(0, 4)),
             int'($urandom_range(0, 4)), 1'b1, $urandom, ($urandom_range(0, 3) == 0), 1'b0);
      n = int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++) begin
        @(posedge clk); #1;
      end
    end

    prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_txn(1'b0, 32'h100 + 32'(4 * i), $urandom, 0, 0, 1'b1, 32'h0, 1'b0, 1'b1);
      if (i > 0) check("b2b_spacing", 96'(last_accept - prev), 96'(2));
      prev = last_accept;
    end
    req_valid = 1'b0;

    stray_pulses(10);
    #1 check("stray_partial", 96'(stray_cnt), 96'(stray_model));
    stray_pulses(300);
    #1 check("stray_saturate", 96'(stray_cnt), 96'(255));

    // Reset pulsed while a read waits in RSP: no completion may appear.
    req_read = 1'b1;
    req_addr = 32'h44;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    icb.cmd_ready = 1'b1;
    @(posedge clk); #1;
    icb.cmd_ready = 1'b0;
    check("busy_in_rsp", 96'({busy, icb.cmd_valid}), 96'(2'b10));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    check("midrst_outputs", 96'({icb.cmd_valid, done_valid, done_err, busy, req_ready}), 96'(0));
    check("midrst_data", {done_rdata, icb.cmd_addr, 24'h0, stray_cnt}, 96'(0));
    stray_model = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    do_txn(1'b1, 32'h48, 32'h0, 1, 2, 1'b1, 32'h600DD00D, 1'b0, 1'b0);
    #1 check("stray_after_rst", 96'(stray_cnt), 96'(stray_model));

    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icb_master_port.md
Name: icb_master_port

Overview:
- Single-outstanding ICB initiator. It converts a local request/done handshake into ICB command and response transactions.
- Sits between a local controller (stepper sequencer, DMA-lite) and an ICB target such as the arm register file.
- Adds a response timeout, error reporting and a count of stray responses.

Parameters:
- TIMEOUT_CYC, 256, cycles allowed from cmd issue to rsp before abort (range 2..65535)
- CNT_W, 16, width of the timeout counter
- STRAY_W, 8, width of the saturating stray-response counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  local request present
- req_ready  out  1  block can accept a request
- req_read  in  1  1=read, 0=write
- req_addr  in  32  target address
- req_wdata  in  32  write data
- done_valid  out  1  one-cycle completion pulse
- done_rdata  out  32  read data (0 for writes or errors)
- done_err  out  1  completion was a timeout or target error
- o_icb_cmd_valid  out  1  ICB command valid
- o_icb_cmd_ready  in  1  ICB command accepted
- o_icb_cmd_addr  out  32  ICB address
- o_icb_cmd_read  out  1  ICB read flag
- o_icb_cmd_wdata  out  32  ICB write data
- o_icb_rsp_valid  in  1  ICB response valid
- o_icb_rsp_ready  out  1  response accept, tied to 1
- o_icb_rsp_rdata  in  32  ICB read data
- o_icb_rsp_err  in  1  ICB target error
- stray_cnt  out  STRAY_W  number of responses received in IDLE, saturating
- busy  out  1  state != IDLE

Behaviour:
- Clocking and reset: one clock domain (clk). Asynchronous active-low reset rst_n.
- Reset values:
  - state=IDLE, all ICB outputs 0, done_valid=0, done_rdata=0, done_err=0, stray_cnt=0, timer=0.
  - req_ready=1 once reset is released.
- Reset asserted mid-transaction: abort immediately with no done pulse; the next request starts clean.
- States: IDLE, CMD, RSP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch read/addr/wdata into the cmd registers, clear the timer, and go to CMD next cycle.
  - req_ready is 0 in CMD and RSP.
- CMD:
  - o_icb_cmd_valid=1. addr/read/wdata are held stable until the handshake.
  - On cmd_valid&cmd_ready: drop cmd_valid the next cycle.
    - If rsp_valid is high in the same cycle (combinational write response), complete directly and go to IDLE.
    - Otherwise go to RSP.
- RSP: wait for rsp_valid, then complete and go to IDLE.
- Completion:
  - done_valid=1 for exactly one cycle, registered, in the cycle after the rsp handshake.
  - done_rdata = rsp_rdata for reads, 0 for writes.
  - done_err = rsp_err.
- Minimum latencies (req_valid at cycle 0):
  - cmd_valid at cycle 1.
  - Same-cycle response: done at cycle 2.
  - Next-cycle response (registered read): done at cycle 3.
- Timeout:
  - The timer increments every cycle in CMD and RSP and saturates.
  - When it reaches TIMEOUT_CYC-1 without a rsp handshake: deassert cmd_valid, go to IDLE, pulse done with done_err=1 and done_rdata=0.
  - A response arriving in the same cycle as the timeout wins: normal completion, no error.
- Stray responses:
  - rsp_valid while in IDLE is accepted and discarded.
  - stray_cnt increments and saturates at all-ones; it never wraps.
- Request while busy: ignored (req_ready=0); the local side must hold it.
- A req_valid in the same cycle as done_valid is accepted (state is IDLE) and starts a new transaction.
- busy is combinational from state.

Decomposition:
- Package icb_mst_pkg:
  - state enum (IDLE=2'd0, CMD=2'd1, RSP=2'd2)
  - default TIMEOUT_CYC
  - ICB data/address width constants (32)
- Sub-module icb_mst_timer: clear/enable/saturating counter with expire flag, parameterised by CNT_W and TIMEOUT_CYC.
- FSM, datapath latches and stray counter stay in the top module.

Test Plan:
- Write, cmd_ready=1, rsp_valid same cycle: req write addr=0x04, wdata=0xDEADBEEF -> cmd_valid at cycle 1 with addr 0x04, read=0; done_valid at cycle 2, done_err=0, done_rdata=0.
- Read, cmd_ready=1, rsp one cycle later with rdata=0x12345678 -> done at cycle 3 with done_rdata=0x12345678, done_err=0.
- cmd_ready held low 3 cycles -> addr/wdata/read stable throughout; req_ready=0; completion follows the eventual handshake.
- TIMEOUT_CYC=8, target never responds -> done_valid with done_err=1 and rdata=0 exactly 8 cycles after cmd_valid rises; state back to IDLE; a late rsp_valid increments stray_cnt to 1.
- Edge cases:
  - rsp_err=1 on a read -> done_err=1.
  - 300 stray responses with STRAY_W=8 -> stray_cnt=255.
  - rst_n pulsed low while in RSP -> all outputs at reset values, no done pulse.
- Back-to-back: req_valid held high for 4 writes with same-cycle responses -> 4 done pulses, each transaction 2 cycles apart.
